// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, coordinate type and scheduler state encoding
// for the write-port scheduler.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;

  typedef logic [10:0] coord_t;

  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } sched_state_t;

  function automatic logic in_bounds(input coord_t x, input coord_t y,
                                     input coord_t x_lim, input coord_t y_lim);
    return (x < x_lim) && (y < y_lim);
  endfunction

endpackage

// File: rtl/fb_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after
// ptr, wrapping. The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] req_shift;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;
  logic [2*NREQ-1:0] gnt_dbl;

  // Rotate so bit 0 is the pointer position, isolate the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    req_dbl   = {req, req};
    req_shift = req_dbl >> ptr;
    req_rot   = req_shift[NREQ-1:0];
    gnt_rot   = req_rot & (~req_rot + NREQ'(1));
    gnt_dbl   = {gnt_rot, gnt_rot} << ptr;
    grant     = gnt_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/fb_write_sched.sv
// Write-port scheduler for the B/W VGA framebuffer: round-robin sharing among
// drawing clients, a priority full-screen clear sweep and out-of-range dropping.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int NREQ   = 2
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               clear_start,
  input  logic               clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [11*NREQ-1:0] req_x,
  input  logic [11*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]    req_color,
  output logic [NREQ-1:0]    req_grant,
  output logic [10:0]        fb_x,
  output logic [10:0]        fb_y,
  output logic               fb_color,
  output logic               fb_write
);

  localparam int     PW     = $clog2(NREQ);
  localparam coord_t X_LIM  = coord_t'(WIDTH);
  localparam coord_t Y_LIM  = coord_t'(HEIGHT);
  localparam coord_t X_LAST = coord_t'(WIDTH - 1);
  localparam coord_t Y_LAST = coord_t'(HEIGHT - 1);

  sched_state_t state_q, state_d;
  coord_t       cx_q, cx_d;
  coord_t       cy_q, cy_d;
  logic         clr_color_q, clr_color_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [PW-1:0] ptr_q, ptr_d;
  coord_t       fb_x_q, fb_x_d;
  coord_t       fb_y_q, fb_y_d;
  logic         fb_color_q, fb_color_d;
  logic         fb_write_q, fb_write_d;

  logic [NREQ-1:0] arb_grant;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   sel_idx;
  coord_t          sel_x;
  coord_t          sel_y;
  logic            sel_color;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // Grant is one-hot, so a plain priority scan is an exact mux.
  always_comb begin
    sel_idx   = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_idx   = PW'(i);
        sel_x     = req_x[11*i +: 11];
        sel_y     = req_y[11*i +: 11];
        sel_color = req_color[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    clr_color_d = clr_color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ptr_d       = ptr_q;
    fb_x_d      = fb_x_q;
    fb_y_d      = fb_y_q;
    fb_color_d  = fb_color_q;
    fb_write_d  = 1'b0;
    grant       = '0;

    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d     = CLEAR;
          clr_color_d = clear_color;
          cx_d        = '0;
          cy_d        = '0;
          busy_d      = 1'b1;
        end else if (|arb_grant) begin
          grant      = arb_grant;
          fb_x_d     = sel_x;
          fb_y_d     = sel_y;
          fb_color_d = sel_color;
          fb_write_d = in_bounds(sel_x, sel_y, X_LIM, Y_LIM);
          ptr_d      = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      CLEAR: begin
        fb_x_d     = cx_q;
        fb_y_d     = cy_q;
        fb_color_d = clr_color_q;
        fb_write_d = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + 11'd1;
          end
        end else begin
          cx_d = cx_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      clr_color_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ptr_q       <= '0;
      fb_x_q      <= '0;
      fb_y_q      <= '0;
      fb_color_q  <= 1'b0;
      fb_write_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      clr_color_q <= clr_color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ptr_q       <= ptr_d;
      fb_x_q      <= fb_x_d;
      fb_y_q      <= fb_y_d;
      fb_color_q  <= fb_color_d;
      fb_write_q  <= fb_write_d;
    end
  end

  // Grant is combinational from IDLE state, so hold it low while reset is asserted.
  assign req_grant  = reset ? '0 : grant;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_color   = fb_color_q;
  assign fb_write   = fb_write_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench: full-size instance for arbitration and range checks, a
// reduced-geometry instance for clear sweep, collision and reset-abort.
module tb_fb_write_sched;

  localparam int SW = 40;
  localparam int SH = 30;
  localparam int SN = SW * SH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m_clear_start, m_clear_color, m_clear_busy, m_clear_done;
  logic [1:0]  m_valid, m_color, m_grant;
  logic [21:0] m_x, m_y;
  logic [10:0] m_fb_x, m_fb_y;
  logic        m_fb_color, m_fb_write;

  logic        s_clear_start, s_clear_color, s_clear_busy, s_clear_done;
  logic [1:0]  s_valid, s_color, s_grant;
  logic [21:0] s_x, s_y;
  logic [10:0] s_fb_x, s_fb_y;
  logic        s_fb_color, s_fb_write;

  fb_write_sched #(.WIDTH(640), .HEIGHT(480), .NREQ(2)) u_main (
    .clk50(clk), .reset(reset),
    .clear_start(m_clear_start), .clear_color(m_clear_color),
    .clear_busy(m_clear_busy), .clear_done(m_clear_done),
    .req_valid(m_valid), .req_x(m_x), .req_y(m_y), .req_color(m_color),
    .req_grant(m_grant),
    .fb_x(m_fb_x), .fb_y(m_fb_y), .fb_color(m_fb_color), .fb_write(m_fb_write)
  );

  fb_write_sched #(.WIDTH(SW), .HEIGHT(SH), .NREQ(2)) u_small (
    .clk50(clk), .reset(reset),
    .clear_start(s_clear_start), .clear_color(s_clear_color),
    .clear_busy(s_clear_busy), .clear_done(s_clear_done),
    .req_valid(s_valid), .req_x(s_x), .req_y(s_y), .req_color(s_color),
    .req_grant(s_grant),
    .fb_x(s_fb_x), .fb_y(s_fb_y), .fb_color(s_fb_color), .fb_write(s_fb_write)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] valid;
    int         x0, y0;
    logic       c0;
    int         x1, y1;
    logic       c1;
    logic [1:0] g;
    logic       w;
    int         ex, ey;
    logic       ec;
  } vec_t;

  vec_t tbl[17];

  int          busy_cnt, done_cnt, done_k, gnt_busy, wr_err, w;
  logic [21:0] first_xy, row1_xy, last_xy;
  logic [1:0]  end_grant, after_grant;
  logic [10:0] after_x, after_y;
  logic        after_w, after_c;

  initial begin
    //            valid  x0  y0  c0    x1    y1   c1    g   w    ex   ey   ec
    tbl[0]  = '{2'b00 | 2'b01,   5,   7, 1'b1,    0,    0, 1'b0, 2'b01, 1'b1,    5,    7, 1'b1};
    tbl[1]  = '{2'b00,   0,   0, 1'b0,    0,    0, 1'b0, 2'b00, 1'b0,    5,    7, 1'b1};
    tbl[2]  = '{2'b01,   9,   9, 1'b0,    0,    0, 1'b0, 2'b01, 1'b1,    9,    9, 1'b0};
    tbl[3]  = '{2'b10,   0,   0, 1'b0,  100,  200, 1'b1, 2'b10, 1'b1,  100,  200, 1'b1};
    tbl[4]  = '{2'b11,  11,  20, 1'b1,   31,   40, 1'b0, 2'b01, 1'b1,   11,   20, 1'b1};
    tbl[5]  = '{2'b11,  12,  20, 1'b1,   31,   40, 1'b0, 2'b10, 1'b1,   31,   40, 1'b0};
    tbl[6]  = '{2'b11,  12,  20, 1'b1,   32,   40, 1'b0, 2'b01, 1'b1,   12,   20, 1'b1};
    tbl[7]  = '{2'b11,  13,  20, 1'b1,   32,   40, 1'b0, 2'b10, 1'b1,   32,   40, 1'b0};
    tbl[8]  = '{2'b11,  13,  20, 1'b1,   33,   40, 1'b0, 2'b01, 1'b1,   13,   20, 1'b1};
    tbl[9]  = '{2'b11,  14,  20, 1'b1,   33,   40, 1'b0, 2'b10, 1'b1,   33,   40, 1'b0};
    tbl[10] = '{2'b10,   0,   0, 1'b0,  640,   10, 1'b1, 2'b10, 1'b0,  640,   10, 1'b1};
    tbl[11] = '{2'b10,   0,   0, 1'b0,    3,  480, 1'b0, 2'b10, 1'b0,    3,  480, 1'b0};
    tbl[12] = '{2'b01, 639, 479, 1'b1,    0,    0, 1'b0, 2'b01, 1'b1,  639,  479, 1'b1};
    tbl[13] = '{2'b10,   0,   0, 1'b0, 2047, 2047, 1'b1, 2'b10, 1'b0, 2047, 2047, 1'b1};
    tbl[14] = '{2'b11,   0,   0, 1'b0,  639,    0, 1'b1, 2'b01, 1'b1,    0,    0, 1'b0};
    tbl[15] = '{2'b01, 640, 479, 1'b1,    0,    0, 1'b0, 2'b01, 1'b0,  640,  479, 1'b1};
    tbl[16] = '{2'b10,   0,   0, 1'b0,  639,  480, 1'b0, 2'b10, 1'b0,  639,  480, 1'b0};

    reset = 1'b1;
    m_clear_start = 1'b0; m_clear_color = 1'b0;
    s_clear_start = 1'b0; s_clear_color = 1'b0;
    m_valid = 2'b11; m_x = '0; m_y = '0; m_color = 2'b11;
    s_valid = 2'b11; s_x = '0; s_y = '0; s_color = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst m_grant", m_grant, 0);
    chk("rst s_grant", s_grant, 0);
    chk("rst fb_write", m_fb_write, 0);
    chk("rst fb_xy", {m_fb_x, m_fb_y}, 0);
    chk("rst fb_color", m_fb_color, 0);
    chk("rst busy_done", {m_clear_busy, m_clear_done, s_clear_busy, s_clear_done}, 0);
    @(negedge clk);
    reset = 1'b0;
    m_valid = 2'b00;
    s_valid = 2'b00;

    // Table-driven arbitration and range checks on the full-size instance.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      m_valid = tbl[i].valid;
      m_x     = {11'(tbl[i].x1), 11'(tbl[i].x0)};
      m_y     = {11'(tbl[i].y1), 11'(tbl[i].y0)};
      m_color = {tbl[i].c1, tbl[i].c0};
      #1;
      chk($sformatf("v%0d grant", i), m_grant, tbl[i].g);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d fb_write", i), m_fb_write, tbl[i].w);
      chk($sformatf("v%0d fb_x", i), m_fb_x, tbl[i].ex);
      chk($sformatf("v%0d fb_y", i), m_fb_y, tbl[i].ey);
      chk($sformatf("v%0d fb_color", i), m_fb_color, tbl[i].ec);
    end
    @(negedge clk);
    m_valid = 2'b00;

    // Clear sweep with a colliding request pair and an ignored second start.
    @(negedge clk);
    s_valid = 2'b11;
    s_x = {11'd7, 11'd3};
    s_y = {11'd8, 11'd4};
    s_color = 2'b10;
    s_clear_start = 1'b1;
    s_clear_color = 1'b1;
    #1;
    chk("collide grant", s_grant, 0);
    busy_cnt = 0; done_cnt = 0; done_k = -1; gnt_busy = 0; wr_err = 0;
    first_xy = '0; row1_xy = '0; last_xy = '0;
    end_grant = '0; after_grant = '0; after_x = '0; after_y = '0;
    after_w = 1'b0; after_c = 1'b1;
    for (int k = 0; k <= SN + 1; k++) begin
      @(negedge clk);
      s_clear_start = (k == 100);
      if (k == 1) s_clear_color = 1'b0;
      if (k == SN + 1) s_valid = 2'b10;
      #1;
      if (s_clear_busy) busy_cnt++;
      if (s_clear_done) begin done_cnt++; done_k = k; end
      if (k < SN && s_grant !== 2'b00) gnt_busy++;
      if (k == 0 && s_fb_write !== 1'b0) wr_err++;
      if (k >= 1 && k <= SN) begin
        w = k - 1;
        if (s_fb_write !== 1'b1 || s_fb_x !== 11'(w % SW) ||
            s_fb_y !== 11'(w / SW) || s_fb_color !== 1'b1) wr_err++;
      end
      if (k == 1)      first_xy = {s_fb_x, s_fb_y};
      if (k == SW + 1) row1_xy  = {s_fb_x, s_fb_y};
      if (k == SN)     begin last_xy = {s_fb_x, s_fb_y}; end_grant = s_grant; end
      if (k == SN + 1) begin
        after_x = s_fb_x; after_y = s_fb_y; after_w = s_fb_write;
        after_c = s_fb_color; after_grant = s_grant;
      end
    end
    s_valid = 2'b00;
    chk("clr busy cycles", busy_cnt, SN);
    chk("clr done count", done_cnt, 1);
    chk("clr done cycle", done_k, SN);
    chk("clr grants while busy", gnt_busy, 0);
    chk("clr write sequence errs", wr_err, 0);
    chk("clr first xy", first_xy, {11'd0, 11'd0});
    chk("clr row1 xy", row1_xy, {11'd0, 11'd1});
    chk("clr last xy", last_xy, {11'(SW - 1), 11'(SH - 1)});
    chk("post-clr pending grant", end_grant, 2'b01);
    chk("post-clr write", {after_w, after_c}, 2'b10);
    chk("post-clr xy", {after_x, after_y}, {11'd3, 11'd4});
    chk("post-clr rr grant", after_grant, 2'b10);

    // Reset asserted mid-sweep aborts asynchronously; next start begins at (0,0).
    @(negedge clk);
    s_clear_start = 1'b1;
    s_clear_color = 1'b1;
    @(negedge clk);
    s_clear_start = 1'b0;
    repeat (999) @(negedge clk);
    #1;
    chk("pre-reset busy", s_clear_busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort busy_done", {s_clear_busy, s_clear_done}, 0);
    chk("abort fb_write", s_fb_write, 0);
    chk("abort fb_xy", {s_fb_x, s_fb_y}, 0);
    chk("abort fb_color", s_fb_color, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    s_clear_start = 1'b1;
    s_clear_color = 1'b0;
    @(negedge clk);
    s_clear_start = 1'b0;
    #1;
    chk("restart busy", {s_clear_busy, s_fb_write}, 2'b10);
    @(posedge clk);
    #1;
    chk("restart first", {s_fb_write, s_fb_color, s_fb_x, s_fb_y}, {1'b1, 1'b0, 11'd0, 11'd0});
    @(posedge clk);
    #1;
    chk("restart second", {s_fb_write, s_fb_x, s_fb_y}, {1'b1, 11'd1, 11'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Write-port scheduler in front of the black-and-white VGA framebuffer's single pixel write port (x, y, pixel_color, pixel_write).
- Shares that port round-robin between NREQ drawing clients (e.g. line drawer, cursor, user input).
- Contains a full-screen clear sequencer that takes priority when triggered.
- Drops out-of-range coordinates so that no write lands outside the 640x480 buffer.

Parameters:
- WIDTH, 640, active pixels per line; also the x bound.
- HEIGHT, 480, active lines; also the y bound.
- NREQ, 2, number of drawing requesters (2..4).

Ports:
- clk50  input  1  system clock; same clock as the framebuffer.
- reset  input  1  asynchronous, active-high reset.
- clear_start  input  1  single-cycle pulse: fill the whole screen with clear_color.
- clear_color  input  1  fill value, sampled in the same cycle as clear_start.
- clear_busy  output  1  high while a clear sweep is in progress.
- clear_done  output  1  one-cycle pulse after the last clear write is issued.
- req_valid  input  NREQ  per-requester write request.
- req_x  input  NREQ x 11  requested x, packed with requester i at [11i+10:11i].
- req_y  input  NREQ x 11  requested y, packed in the same way.
- req_color  input  NREQ  requested pixel value.
- req_grant  output  NREQ  one-hot, combinational; the request is consumed in any cycle where it is high.
- fb_x  output  11  to framebuffer x.
- fb_y  output  11  to framebuffer y.
- fb_color  output  1  to framebuffer pixel_color.
- fb_write  output  1  to framebuffer pixel_write.

Behaviour:
- Reset values:
  - state = IDLE, clear_busy = 0, clear_done = 0.
  - req_grant = 0, fb_x = fb_y = 0, fb_color = 0, fb_write = 0.
  - Round-robin pointer = requester 0.
  - Clear counters = 0.
- Reset asserted mid-clear aborts the sweep immediately. There is no resume.
- Port timing:
  - All fb_* outputs are registered.
  - A write granted in cycle N appears on fb_* in cycle N+1, so fb_write pulses for exactly one cycle per write.
  - At most one write per cycle.
- Handshake:
  - A requester holds req_valid and its data stable until it sees req_grant[i]=1.
  - The grant and the data transfer happen in the same cycle.
  - The requester may drop valid or present new data from the next cycle.
- State machine (2 states):
  - IDLE:
    - If clear_start=1: latch clear_color, set cx = cy = 0, go to CLEAR, clear_busy=1. No grant is issued that cycle.
    - Otherwise: arbitrate among the set req_valid bits.
  - CLEAR:
    - Every cycle, issue a write at (cx, cy) with the latched colour.
    - cx increments. When cx = WIDTH-1, cx wraps to 0 and cy increments.
    - On the write at (WIDTH-1, HEIGHT-1): return to IDLE, clear_busy=0, clear_done=1 for one cycle.
    - The sweep takes exactly WIDTH*HEIGHT = 307200 cycles.
    - req_grant = 0 throughout CLEAR.
    - clear_start during CLEAR is ignored. It does not restart the sweep.
- Arbitration (IDLE only):
  - Round-robin starting at the pointer. The first valid requester at or after the pointer, wrapping, is granted.
  - After a grant to i, the pointer becomes (i+1) mod NREQ.
  - With no valid requests, the pointer is unchanged and fb_write=0 next cycle.
  - A requester that keeps valid high is served at least once every NREQ cycles.
- Range check:
  - A granted request with x >= WIDTH or y >= HEIGHT is consumed (grant still issued) but produces fb_write=0.
  - fb_x/fb_y still update, so debug can see the dropped coordinate.
  - Comparisons are unsigned, 11-bit.
- Counter widths: cx and cy are 11-bit. Wrap is by compare only, never by natural overflow.
- Simultaneous clear_start and req_valid in IDLE: clear wins. The request stays pending and is served after clear_done.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH=640 and FB_HEIGHT=480.
  - Coordinate typedef coord_t (logic [10:0]).
  - Enum sched_state_t {IDLE, CLEAR}.
- One sub-module, rr_arbiter (parameterised NREQ):
  - Inputs: request vector and pointer.
  - Output: one-hot grant.
  - Combinational, with the pointer register kept in fb_write_sched.

Test Plan:
- Reset mid-clear: assert reset at sweep cycle 1000 -> all outputs return to their reset values asynchronously; the next clear_start restarts from (0,0).
- Single request: req_valid=01 with (5,7,1) -> req_grant=01 in the same cycle; next cycle fb_write=1, fb_x=5, fb_y=7, fb_color=1.
- Fairness: both requesters valid for 6 cycles, pointer=0 -> grants alternate 01,10,01,10,01,10; fb_write is high 6 consecutive cycles.
- Out-of-range: requester 1 at (640,10) then (3,480) -> both granted, fb_write=0 both times; requester 0 at (639,479) -> written.
- Clear sweep: clear_start with clear_color=1 -> clear_busy high for exactly 307200 cycles; fb_write high every cycle; first write (0,0), write 640 at (0,1), last write (639,479); clear_done pulses once; no grants during the sweep; a pending req_valid is granted the cycle after clear_done.
- Clear collision: clear_start and req_valid=11 in the same IDLE cycle -> no grant; sweep begins. A second clear_start at cycle 100 of the sweep -> ignored; total length is still 307200.
